// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared framing constants and FSM state type for the UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 234;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock show-ahead FIFO; a push into a full FIFO is ignored.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : 8N1 UART transmitter fed by a byte FIFO; frames go out back-to-back.
//            Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] din,
    output logic                 ack,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 tx
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ack_q;
    logic                 overflow_q;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 bit_done;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr),
        .pop   (fifo_pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign bit_done = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        if (state_q != IDLE && !bit_done) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    parity_d = ^fifo_dout;
                    state_d  = START;
                    tx_d     = 1'b0;
                    cnt_d    = RELOAD;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    cnt_d   = RELOAD;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = RELOAD;
                    if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = RELOAD;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = ^fifo_dout;
                        state_d  = START;
                        tx_d     = 1'b0;
                        cnt_d    = RELOAD;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ack_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ack_q      <= wr && !full;
            overflow_q <= overflow_q || (wr && full);
        end
    end

    assign ack      = ack_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4, depth 8).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ack, full, empty, busy, overflow, tx;

    int checks   = 0;
    int errors   = 0;
    int busy_cnt = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .din      (din),
        .ack      (ack),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one write strobe and returns at the negedge after the sampling edge.
    task automatic write_byte(input logic [7:0] b);
        wr  = 1'b1;
        din = b;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    // Waits for a start bit, then checks every cycle of every bit of the frame.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [NB-1:0] bits;
        int            n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
`endif
        n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_timeout"}, 32'(n >= 500), 32'd0);
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s bit%0d cyc%0d", tag, i, c), 32'(tx), 32'(bits[i]));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int b0;
        int acks;
        int bad;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst tx",       32'(tx),       32'd1);
        check("rst ack",      32'(ack),      32'd0);
        check("rst empty",    32'(empty),    32'd1);
        check("rst full",     32'(full),     32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5
        write_byte(8'hA5);
        check("a5 ack",      32'(ack),   32'd1);
        check("a5 tx_pre",   32'(tx),    32'd1);
        check("a5 empty",    32'(empty), 32'd0);
        check("a5 busy_pre", 32'(busy),  32'd0);
        @(negedge clk);
        check("a5 ack_pulse", 32'(ack),  32'd0);
        check("a5 tx_start",  32'(tx),   32'd0);
        check("a5 busy",      32'(busy), 32'd1);
        check("a5 popped",    32'(empty),32'd1);
        expect_frame(8'hA5, "a5");
        check("a5 busy_post", 32'(busy), 32'd0);
        check("a5 tx_idle",   32'(tx),   32'd1);

        // Back-to-back frames
        repeat (3) @(negedge clk);
        b0 = busy_cnt;
        write_byte(8'h00);
        write_byte(8'hFF);
        expect_frame(8'h00, "b2b0");
        check("b2b no_gap", 32'(tx), 32'd0);
        expect_frame(8'hFF, "b2b1");
        repeat (5) @(negedge clk);
        check("b2b busy_cycles", 32'(busy_cnt - b0), 32'(2 * NB * CPB));

        // Overflow: ten consecutive writes from idle
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            wr  = 1'b1;
            din = 8'(8'h10 + i);
            @(negedge clk);
            check($sformatf("ovf ack%0d", i), 32'(ack), 32'(i < 9));
            if (ack === 1'b1) acks++;
        end
        wr = 1'b0;
        check("ovf acks",     32'(acks),     32'd9);
        check("ovf full",     32'(full),     32'd1);
        check("ovf overflow", 32'(overflow), 32'd1);
        repeat (60) @(negedge clk);
        check("ovf sticky",    32'(overflow), 32'd1);
        check("ovf full_drop", 32'(full),     32'd0);
        rst = 1'b1;
        wr  = 1'b1;
        din = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        check("ovf rst tx",       32'(tx),       32'd1);
        check("ovf rst empty",    32'(empty),    32'd1);
        check("ovf rst full",     32'(full),     32'd0);
        check("ovf rst overflow", 32'(overflow), 32'd0);
        check("ovf rst busy",     32'(busy),     32'd0);
        check("ovf rst ack",      32'(ack),      32'd0);
        @(negedge clk);
        check("rst_wr not_queued", 32'(empty), 32'd1);
        check("rst_wr no_ack",     32'(ack),   32'd0);
        check("rst_wr idle",       32'(busy),  32'd0);

        // Reset in the middle of data bit 3 of 0x3C
        repeat (2) @(negedge clk);
        write_byte(8'h3C);
        repeat (18) @(negedge clk);
        check("mid bit3", 32'(tx), 32'd1);
        check("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst tx",    32'(tx),    32'd1);
        check("mid rst empty", 32'(empty), 32'd1);
        check("mid rst busy",  32'(busy),  32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid quiet", 32'(bad), 32'd0);

        // Parity-relevant bytes (frame length follows the build)
        write_byte(8'h07);
        expect_frame(8'h07, "p07");
        write_byte(8'h03);
        expect_frame(8'h03, "p03");
        repeat (3) @(negedge clk);

        // Pointer wrap: 20 bytes with the FIFO kept partly full
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if (i >= 5) repeat (NB * CPB - 1) @(negedge clk);
                    write_byte(8'(i));
                    check($sformatf("wrap ack%0d", i), 32'(ack), 32'd1);
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    expect_frame(8'(i), $sformatf("wrap%0d", i));
                end
            end
        join
        repeat (5) @(negedge clk);
        check("wrap busy_end",  32'(busy),     32'd0);
        check("wrap empty_end", 32'(empty),    32'd1);
        check("wrap no_ovf",    32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
